// File: rtl/dec_pkg.sv
// Shared types and helpers for the N-to-2^N sequenced decoder.
//   state_e   : controller state (IDLE, DIRECT, SCAN)
//   MODE_*    : encodings of the mode input
//   onehot_w  : number of output lines for a given select width
package dec_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DIRECT = 2'd1,
    SCAN   = 2'd2
  } state_e;

  localparam logic MODE_DIRECT = 1'b0;
  localparam logic MODE_SCAN   = 1'b1;

  function automatic int unsigned onehot_w(input int unsigned sel_w);
    return 32'd1 << sel_w;
  endfunction

endpackage

// File: rtl/dec_onehot.sv
// Combinational SEL_W-to-2**SEL_W one-hot decoder with enable.
//   sel_i    : binary line select
//   en_i     : 0 forces every line low
//   onehot_c : one-hot decode of sel_i (combinational)
module dec_onehot
  import dec_pkg::*;
#(
  parameter int unsigned SEL_W = 2
) (
  input  logic [SEL_W-1:0]      sel_i,
  input  logic                  en_i,
  output logic [(2**SEL_W)-1:0] onehot_c
);

  localparam int unsigned OUT_W = onehot_w(SEL_W);

  // Each line compares against its own index; equivalent to a tree of 1-to-2 stages.
  always_comb begin
    onehot_c = '0;
    for (int unsigned i = 0; i < OUT_W; i++) begin
      onehot_c[i] = en_i && (sel_i == SEL_W'(i));
    end
  end

endmodule

// File: rtl/dec_nto2n_seq.sv
// Registered N-to-2^N one-hot line decoder with valid/ready input, global
// enable and an auto-scan mode with programmable dwell.
//   clk, rst  : clock (rising edge), asynchronous active-high reset
//   en        : global enable; 0 drives outputs inactive
//   mode      : 0 = DIRECT (decode in_sel), 1 = SCAN (auto-walk)
//   in_valid  : in_sel valid (DIRECT only)
//   in_ready  : select accepted this cycle (combinational, en & DIRECT mode)
//   in_sel    : binary line select
//   dwell     : SCAN cycles per line minus one
//   D         : registered one-hot output
//   out_valid : D holds a decoded line
//   cur_sel   : binary index of the active line
// Build option: DEC_ACTIVE_LOW_EN drives D active-low (idle value all-ones).
module dec_nto2n_seq
  import dec_pkg::*;
#(
  parameter int unsigned SEL_W   = 2,
  parameter int unsigned DWELL_W = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  mode,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [SEL_W-1:0]      in_sel,
  input  logic [DWELL_W-1:0]    dwell,
  output logic [(2**SEL_W)-1:0] D,
  output logic                  out_valid,
  output logic [SEL_W-1:0]      cur_sel
);

  localparam int unsigned OUT_W = onehot_w(SEL_W);

`ifdef DEC_ACTIVE_LOW_EN
  localparam logic [OUT_W-1:0] D_IDLE = '1;
`else
  localparam logic [OUT_W-1:0] D_IDLE = '0;
`endif

  state_e             state_q, state_d;
  logic [OUT_W-1:0]   d_q, d_d;
  logic               valid_q, valid_d;
  logic [SEL_W-1:0]   sel_q, sel_d;
  logic [DWELL_W-1:0] cnt_q, cnt_d;
  logic [OUT_W-1:0]   onehot_c;

  assign in_ready = en && (mode == MODE_DIRECT);

  // Next-cycle state, select, valid and dwell count.
  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    cnt_d   = cnt_q;
    valid_d = valid_q;
    if (!en) begin
      state_d = IDLE;
      valid_d = 1'b0;
      cnt_d   = '0;
    end else if (mode == MODE_SCAN) begin
      state_d = SCAN;
      valid_d = 1'b1;
      if (state_q != SCAN) begin
        sel_d = '0;
        cnt_d = '0;
      end else if (cnt_q >= dwell) begin
        // >= so a dwell lowered below the running count advances at once
        sel_d = sel_q + SEL_W'(1);
        cnt_d = '0;
      end else begin
        cnt_d = cnt_q + DWELL_W'(1);
      end
    end else if (in_valid) begin
      state_d = DIRECT;
      sel_d   = in_sel;
      valid_d = 1'b1;
    end
  end

  // Decode the next-cycle select so D is a pure register output.
  dec_onehot #(
    .SEL_W (SEL_W)
  ) u_dec (
    .sel_i    (sel_d),
    .en_i     (valid_d),
    .onehot_c (onehot_c)
  );

`ifdef DEC_ACTIVE_LOW_EN
  assign d_d = ~onehot_c;
`else
  assign d_d = onehot_c;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      d_q     <= D_IDLE;
      valid_q <= 1'b0;
      sel_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      d_q     <= d_d;
      valid_q <= valid_d;
      sel_q   <= sel_d;
      cnt_q   <= cnt_d;
    end
  end

  assign D         = d_q;
  assign out_valid = valid_q;
  assign cur_sel   = sel_q;

endmodule

// File: tb/tb_dec_nto2n_seq.sv
// Directed self-checking bench for dec_nto2n_seq (SEL_W=2, DWELL_W=4).
module tb_dec_nto2n_seq;

  localparam int unsigned SEL_W   = 2;
  localparam int unsigned DWELL_W = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             en, mode, in_valid;
  logic             in_ready;
  logic [SEL_W-1:0] in_sel;
  logic [DWELL_W-1:0] dwell;
  logic [3:0]       D;
  logic             out_valid;
  logic [SEL_W-1:0] cur_sel;

  int checks = 0;
  int errors = 0;

  dec_nto2n_seq #(.SEL_W(SEL_W), .DWELL_W(DWELL_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .mode      (mode),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_sel    (in_sel),
    .dwell     (dwell),
    .D         (D),
    .out_valid (out_valid),
    .cur_sel   (cur_sel)
  );

  always #5 clk = ~clk;

  // Polarity of D as seen on the pins.
  function automatic logic [3:0] pin(input logic [3:0] v);
`ifdef DEC_ACTIVE_LOW_EN
    return ~v;
`else
    return v;
`endif
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; en = 1'b0; mode = 1'b0; in_valid = 1'b0; in_sel = '0; dwell = '0;
    #12;
    checks++; if (D !== pin(4'b0000)) begin errors++; $display("FAIL reset_D got %b exp %b", D, pin(4'b0000)); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", out_valid); end
    checks++; if (cur_sel !== 2'd0) begin errors++; $display("FAIL reset_sel got %0d exp 0", cur_sel); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_ready got %b exp 0", in_ready); end
    tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic test_direct();
    en = 1'b1; mode = 1'b0; in_valid = 1'b1; in_sel = 2'd2;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL direct_ready got %b exp 1", in_ready); end
    tick();
    checks++; if (D !== pin(4'b0100)) begin errors++; $display("FAIL direct_D got %b exp %b", D, pin(4'b0100)); end
    checks++; if (cur_sel !== 2'd2) begin errors++; $display("FAIL direct_sel got %0d exp 2", cur_sel); end
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL direct_valid got %b exp 1", out_valid); end
  endtask

  task automatic test_back_to_back();
    logic [1:0] sels [3];
    logic [3:0] exps [3];
    sels[0] = 2'd0; sels[1] = 2'd3; sels[2] = 2'd1;
    exps[0] = 4'b0001; exps[1] = 4'b1000; exps[2] = 4'b0010;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; in_sel = sels[i];
      tick();
      checks++; if (D !== pin(exps[i])) begin errors++; $display("FAIL b2b_D[%0d] got %b exp %b", i, D, pin(exps[i])); end
      checks++; if (cur_sel !== sels[i]) begin errors++; $display("FAIL b2b_sel[%0d] got %0d exp %0d", i, cur_sel, sels[i]); end
    end
    in_valid = 1'b0; in_sel = 2'd3;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (D !== pin(4'b0010)) begin errors++; $display("FAIL hold_D[%0d] got %b exp %b", i, D, pin(4'b0010)); end
    end
  endtask

  task automatic test_scan();
    logic [1:0] es;
    logic [3:0] ed;
    mode = 1'b1; dwell = 4'd2; in_valid = 1'b1;
    for (int e = 1; e <= 13; e++) begin
      tick();
      es = 2'(((e - 1) / 3) % 4);
      ed = 4'b0001 << es;
      checks++; if (D !== pin(ed)) begin errors++; $display("FAIL scan_D[%0d] got %b exp %b", e, D, pin(ed)); end
      checks++; if (cur_sel !== es) begin errors++; $display("FAIL scan_sel[%0d] got %0d exp %0d", e, cur_sel, es); end
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL scan_ready[%0d] got %b exp 0", e, in_ready); end
    end
    in_valid = 1'b0;
  endtask

  task automatic test_dwell_change();
    dwell = 4'd5;
    tick(); tick(); tick();
    checks++; if (cur_sel !== 2'd0) begin errors++; $display("FAIL dwl_pre got %0d exp 0", cur_sel); end
    dwell = 4'd1;
    tick();
    checks++; if (D !== pin(4'b0010)) begin errors++; $display("FAIL dwl_shrink got %b exp %b", D, pin(4'b0010)); end
    tick();
    checks++; if (cur_sel !== 2'd1) begin errors++; $display("FAIL dwl_stay got %0d exp 1", cur_sel); end
    tick();
    checks++; if (cur_sel !== 2'd2) begin errors++; $display("FAIL dwl_adv got %0d exp 2", cur_sel); end
  endtask

  task automatic test_en_off();
    dwell = 4'd0;
    tick();
    checks++; if (cur_sel !== 2'd3) begin errors++; $display("FAIL d0_step got %0d exp 3", cur_sel); end
    tick();
    checks++; if (D !== pin(4'b0001)) begin errors++; $display("FAIL d0_wrap got %b exp %b", D, pin(4'b0001)); end
    tick();
    checks++; if (cur_sel !== 2'd1) begin errors++; $display("FAIL d0_next got %0d exp 1", cur_sel); end
    en = 1'b0;
    #1;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL off_ready got %b exp 0", in_ready); end
    tick();
    checks++; if (D !== pin(4'b0000)) begin errors++; $display("FAIL off_D got %b exp %b", D, pin(4'b0000)); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL off_valid got %b exp 0", out_valid); end
    checks++; if (cur_sel !== 2'd1) begin errors++; $display("FAIL off_sel got %0d exp 1", cur_sel); end
    en = 1'b1;
    tick();
    checks++; if (D !== pin(4'b0001)) begin errors++; $display("FAIL on_restart got %b exp %b", D, pin(4'b0001)); end
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL on_valid got %b exp 1", out_valid); end
    tick();
    checks++; if (D !== pin(4'b0010)) begin errors++; $display("FAIL on_step got %b exp %b", D, pin(4'b0010)); end
  endtask

  task automatic test_scan_to_direct();
    mode = 1'b0; in_valid = 1'b1; in_sel = 2'd2;
    tick();
    checks++; if (D !== pin(4'b0100)) begin errors++; $display("FAIL s2d_first got %b exp %b", D, pin(4'b0100)); end
    mode = 1'b1; in_valid = 1'b0;
    tick();
    checks++; if (D !== pin(4'b0001)) begin errors++; $display("FAIL d2s_entry got %b exp %b", D, pin(4'b0001)); end
    tick();
    mode = 1'b0;
    tick(); tick();
    checks++; if (D !== pin(4'b0010)) begin errors++; $display("FAIL s2d_hold got %b exp %b", D, pin(4'b0010)); end
    checks++; if (cur_sel !== 2'd1) begin errors++; $display("FAIL s2d_hold_sel got %0d exp 1", cur_sel); end
    in_valid = 1'b1; in_sel = 2'd3;
    tick();
    checks++; if (D !== pin(4'b1000)) begin errors++; $display("FAIL s2d_xfer got %b exp %b", D, pin(4'b1000)); end
    in_valid = 1'b0;
  endtask

  task automatic test_async_reset();
    mode = 1'b1; dwell = 4'd0;
    tick(); tick(); tick(); tick();
    checks++; if (D !== pin(4'b1000)) begin errors++; $display("FAIL ar_pre got %b exp %b", D, pin(4'b1000)); end
    rst = 1'b1;
    #2;
    checks++; if (D !== pin(4'b0000)) begin errors++; $display("FAIL ar_D got %b exp %b", D, pin(4'b0000)); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL ar_valid got %b exp 0", out_valid); end
    checks++; if (cur_sel !== 2'd0) begin errors++; $display("FAIL ar_sel got %0d exp 0", cur_sel); end
    rst = 1'b0;
    tick();
    checks++; if (D !== pin(4'b0001)) begin errors++; $display("FAIL ar_restart got %b exp %b", D, pin(4'b0001)); end
  endtask

  initial begin
    test_reset();
    test_direct();
    test_back_to_back();
    test_scan();
    test_dwell_change();
    test_en_off();
    test_scan_to_direct();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dec_nto2n_seq.md
Name: dec_nto2n_seq

Overview:
Parametrised, registered N-to-2^N one-hot line decoder. Successor to the fixed 2-to-4 decoder built from 1-to-2 stages.
Adds a valid/ready input handshake, a global enable and an auto-scan mode. In auto-scan mode an internal counter walks the one-hot output across all lines with a programmable dwell. Used for row/digit/bank select, e.g. multiplexed display scanning and chip-select fan-out.

Parameters:
SEL_W, 2, select width N; output width is 2**SEL_W (legal 1..6)
DWELL_W, 4, width of dwell counter/port

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-high reset
en  in  1  global enable; 0 forces outputs inactive
mode  in  1  0 = DIRECT (decode in_sel), 1 = SCAN (auto-walk)
in_valid  in  1  in_sel valid (DIRECT only)
in_ready  out  1  block accepts in_sel this cycle
in_sel  in  SEL_W  binary line select
dwell  in  DWELL_W  SCAN: cycles per line = dwell+1
D  out  2**SEL_W  registered one-hot decode output
out_valid  out  1  D holds a decoded line (exactly one bit active)
cur_sel  out  SEL_W  binary index of the active line

Behaviour:
- Reset (async assert, sync-safe release):
  - D=0, out_valid=0, cur_sel=0, dwell counter=0, state=IDLE.
- States:
  - IDLE: en=0 or nothing accepted yet.
  - DIRECT: holding the last accepted select.
  - SCAN: auto-walk.
- State transitions, evaluated each clock:
  - en=0 -> IDLE from any state. Next edge: D=0, out_valid=0, cur_sel held, dwell counter cleared.
  - en=1 & mode=1 -> SCAN.
  - en=1 & mode=0 & accepted transfer -> DIRECT.
  - Otherwise stay in the current state.
- in_ready = en & ~mode (combinational). It is never asserted in SCAN or with en=0.
- DIRECT:
  - Transfer on in_valid & in_ready.
  - Next edge: D = 1<<in_sel, cur_sel = in_sel, out_valid = 1. Latency is 1 cycle.
  - With no transfer, D holds its value indefinitely.
  - Back-to-back transfers are accepted every cycle; each is reflected one cycle later.
- SCAN:
  - On entry from IDLE/DIRECT: the first SCAN edge loads cur_sel=0, D=1, out_valid=1, and clears the dwell counter.
  - The dwell counter increments each cycle. When it equals dwell: cur_sel increments, the counter clears, D = 1<<(cur_sel+1).
  - Wrap-around: cur_sel 2**SEL_W-1 -> 0.
  - dwell=0 advances every cycle.
  - A dwell change mid-line is compared against the live value. If the counter already exceeds the new dwell, advance on the next edge.
- Mode change SCAN->DIRECT:
  - D holds the last scanned line until a transfer occurs.
  - A transfer in the first DIRECT cycle is honoured.
- Reset asserted mid-operation: all outputs go to reset values immediately, without waiting for a clock edge.
- Invariant: out_valid=1 implies D has exactly one bit set, equal to 1<<cur_sel. out_valid=0 implies D=0.
- Sizing:
  - Dwell counter width is DWELL_W.
  - cur_sel arithmetic is modulo 2**SEL_W; no overflow flag.

Optional Feature:
DEC_ACTIVE_LOW_EN
- Defined:
  - D is driven inverted (active-low one-hot); reset and inactive value is all-ones.
  - out_valid, cur_sel and in_ready are unchanged.
  - Inversion is applied at the output register input, so D stays glitch-free.
- Undefined: active-high as described above.

Decomposition:
- Shared package dec_pkg holds:
  - state enum {IDLE, DIRECT, SCAN}
  - mode constants MODE_DIRECT=0, MODE_SCAN=1
  - function onehot_w(sel_w) returning 2**sel_w
- Sub-module dec_onehot: purely combinational SEL_W-to-2**SEL_W decoder with enable. It is the generalised form of the 1-to-2 stage tree.
- dec_nto2n_seq instantiates dec_onehot once, feeding it the next-cycle select, and registers the result.

Test Plan:
- Reset then SEL_W=2, en=1, mode=0, in_valid=1, in_sel=2 -> in_ready=1; next edge D=4'b0100, cur_sel=2, out_valid=1.
- DIRECT back-to-back in_sel 0,3,1 on consecutive cycles -> D = 0001, 1000, 0010 on the following three edges; then in_valid=0 -> D holds 0010.
- mode=1, dwell=2 -> D = 0001 for 3 cycles, then 0010, 0100, 1000, then wraps to 0001 after 12 cycles total; in_ready=0 throughout.
- SCAN with dwell=0, then en=0 mid-line -> next edge D=0, out_valid=0; en=1 -> restarts at D=0001.
- rst pulsed (no clock edge) while D=1000 in SCAN -> D=0, cur_sel=0, out_valid=0 immediately.
- Compile with DEC_ACTIVE_LOW_EN, SEL_W=3, in_sel=5 -> D=8'b11011111; after reset D=8'hFF.
